// File: rtl/sin_cos_eval_if.sv
// Handshake and coefficient-table bundle for the sin/cos evaluator.
// The slave side is the evaluator; the master side is its environment (phase source, table, sink).
interface sin_cos_eval_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_phase;
    logic [6:0]  coeff_addr;
    logic [18:0] coeff_c0;
    logic [11:0] coeff_c1;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] out_cos;
    logic [19:0] out_sin;

    modport master (
        output in_valid, in_phase, coeff_c0, coeff_c1, out_ready,
        input  in_ready, coeff_addr, out_valid, out_cos, out_sin
    );

    modport slave (
        input  in_valid, in_phase, coeff_c0, coeff_c1, out_ready,
        output in_ready, coeff_addr, out_valid, out_cos, out_sin
    );
endinterface

// File: rtl/sin_cos_eval.sv
// Piecewise-linear sine/cosine evaluator: two reads of a first-quadrant cosine table,
// c0 - c1*x per segment with clamp at zero, then quadrant folding to signed outputs.
//
// state  | meaning
// IDLE   | ready for a phase; accept latches the phase
// LOOK_A | table read addressed with segment of a
// LOOK_B | table data for a -> MA; table read addressed with segment of ~a
// CALC   | table data for ~a -> MB; fold by quadrant into cos/sin registers
// DONE   | result presented until downstream accepts
module sin_cos_eval (
    input  logic           clk,
    input  logic           rst_n,
    sin_cos_eval_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, LOOK_A, LOOK_B, CALC, DONE} state_t;

    state_t      state_q, state_d;
    logic [15:0] phase_q, phase_d;
    logic [18:0] ma_q, ma_d;
    logic [19:0] cos_q, cos_d;
    logic [19:0] sin_q, sin_d;

    logic [13:0] ang_a;
    logic [13:0] ang_b;
    logic [6:0]  x_sel;
    logic [18:0] mag;
    logic [19:0] ma_ext;
    logic [19:0] mb_ext;

    function automatic logic [18:0] seg_mag(input logic [18:0] c0,
                                            input logic [11:0] c1,
                                            input logic [6:0]  x);
        logic [18:0] prod;
        logic [18:0] drop;
        prod = c1 * x;
        drop = {7'd0, prod[18:7]};
        // Clamp rather than wrap when the slope term overshoots c0.
        if (drop > c0) begin
            return '0;
        end
        return c0 - drop;
    endfunction

    assign ang_a  = phase_q[13:0];
    assign ang_b  = ~phase_q[13:0];
    // The table data in LOOK_B belongs to a, in CALC to b; one evaluator serves both.
    assign x_sel  = (state_q == LOOK_B) ? ang_a[6:0] : ang_b[6:0];
    assign mag    = seg_mag(bus.coeff_c0, bus.coeff_c1, x_sel);
    assign ma_ext = {1'b0, ma_q};
    assign mb_ext = {1'b0, mag};

    assign bus.in_ready   = (state_q == IDLE);
    assign bus.out_valid  = (state_q == DONE);
    assign bus.coeff_addr = (state_q == LOOK_B) ? ang_b[13:7] : ang_a[13:7];
    assign bus.out_cos    = cos_q;
    assign bus.out_sin    = sin_q;

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        ma_d    = ma_q;
        cos_d   = cos_q;
        sin_d   = sin_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    phase_d = bus.in_phase;
                    state_d = LOOK_A;
                end
            end
            LOOK_A: state_d = LOOK_B;
            LOOK_B: begin
                ma_d    = mag;
                state_d = CALC;
            end
            CALC: begin
                unique case (phase_q[15:14])
                    2'd0: begin cos_d = ma_ext;         sin_d = mb_ext;         end
                    2'd1: begin cos_d = 20'd0 - mb_ext; sin_d = ma_ext;         end
                    2'd2: begin cos_d = 20'd0 - ma_ext; sin_d = 20'd0 - mb_ext; end
                    2'd3: begin cos_d = mb_ext;         sin_d = 20'd0 - ma_ext; end
                endcase
                state_d = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            phase_q <= '0;
            ma_q    <= '0;
            cos_q   <= '0;
            sin_q   <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            ma_q    <= ma_d;
            cos_q   <= cos_d;
            sin_q   <= sin_d;
        end
    end
endmodule

// File: tb/tb_sin_cos_eval.sv
// Self-checking bench for sin_cos_eval: fixed vectors, backpressure, mid-op reset,
// and a randomized sweep against an arithmetic reference model.
module tb_sin_cos_eval;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sin_cos_eval_if bus();
    sin_cos_eval dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    logic [18:0] tc0 [128];
    logic [11:0] tc1 [128];

    // Table model: registered read, one cycle of latency.
    always @(posedge clk) begin
        bus.coeff_c0 <= tc0[bus.coeff_addr];
        bus.coeff_c1 <= tc1[bus.coeff_addr];
    end

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] ph;
        int          c0;
        int          c1;
        int          ec;
        int          es;
    } vec_t;
    vec_t vecs [6];

    int qc [$];
    int qs [$];

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic timeout_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s actual=timeout required=event", name);
    endtask

    task automatic fill_table(input int c0, input int c1);
        for (int i = 0; i < 128; i++) begin
            tc0[i] = c0[18:0];
            tc1[i] = c1[11:0];
        end
    endtask

    function automatic int mag_ref(input int c0, input int c1, input int x);
        int dropv;
        dropv = (c1 * x) / 128;
        if (dropv > c0) return 0;
        return c0 - dropv;
    endfunction

    function automatic void ref_fold(input logic [15:0] ph, output int rc, output int rs);
        int a, b, ma, mb;
        a  = int'(ph[13:0]);
        b  = 16383 - a;
        ma = mag_ref(int'(tc0[a / 128]), int'(tc1[a / 128]), a % 128);
        mb = mag_ref(int'(tc0[b / 128]), int'(tc1[b / 128]), b % 128);
        case (ph[15:14])
            2'd0:    begin rc =  ma; rs =  mb; end
            2'd1:    begin rc = -mb; rs =  ma; end
            2'd2:    begin rc = -ma; rs = -mb; end
            default: begin rc =  mb; rs = -ma; end
        endcase
    endfunction

    // Called at #1 after a posedge with the DUT idle and out_ready high.
    task automatic run_op(input string tag, input logic [15:0] ph, input int ec, input int es);
        int n;
        logic [6:0] seg_a;
        logic [6:0] seg_b;
        seg_a = ph[13:7];
        seg_b = ~seg_a;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.in_ready) begin
            timeout_fail({tag, "_idle"});
            return;
        end
        bus.in_valid = 1'b1;
        bus.in_phase = ph;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk({tag, "_ready_busy"}, bus.in_ready, 0);
        chk({tag, "_addr_a"}, bus.coeff_addr, seg_a);
        @(posedge clk); #1;
        chk({tag, "_addr_b"}, bus.coeff_addr, seg_b);
        @(posedge clk); #1;
        chk({tag, "_valid_early"}, bus.out_valid, 0);
        @(posedge clk); #1;
        chk({tag, "_valid_t4"}, bus.out_valid, 1);
        chk({tag, "_cos"}, $signed(bus.out_cos), ec);
        chk({tag, "_sin"}, $signed(bus.out_sin), es);
        @(posedge clk); #1;
    endtask

    initial begin
        int ec, es, n, got, seen;
        logic [15:0] p1, p2, p3;

        vecs[0] = '{16'h0040, 32'h40000, 256,  262016,  262018};
        vecs[1] = '{16'h4040, 32'h40000, 256, -262018,  262016};
        vecs[2] = '{16'h8040, 32'h40000, 256, -262016, -262018};
        vecs[3] = '{16'hC040, 32'h40000, 256,  262018, -262016};
        vecs[4] = '{16'h007F, 10,        4095,       0,      10};
        vecs[5] = '{16'h807F, 10,        4095,       0,     -10};

        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_phase = '0;
        bus.out_ready = 1'b1;
        fill_table(32'h40000, 256);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_cos", $signed(bus.out_cos), 0);
        chk("rst_out_sin", $signed(bus.out_sin), 0);
        chk("rst_coeff_addr", bus.coeff_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            fill_table(vecs[i].c0, vecs[i].c1);
            run_op($sformatf("vec%0d", i), vecs[i].ph, vecs[i].ec, vecs[i].es);
        end

        // Backpressure with in_valid held high throughout.
        fill_table(32'h40000, 256);
        p1 = 16'h2345;
        p2 = 16'h1ABC;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_phase  = p1;
        @(posedge clk); #1;
        bus.in_phase = p2;
        repeat (3) begin @(posedge clk); #1; end
        ref_fold(p1, ec, es);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("bp_valid_%0d", i), bus.out_valid, 1);
            chk($sformatf("bp_ready_%0d", i), bus.in_ready, 0);
            chk($sformatf("bp_cos_%0d", i), $signed(bus.out_cos), ec);
            chk($sformatf("bp_sin_%0d", i), $signed(bus.out_sin), es);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_ready", bus.in_ready, 1);
        chk("bp_release_valid", bus.out_valid, 0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("bp_reaccept_busy", bus.in_ready, 0);
        chk("bp_reaccept_addr", bus.coeff_addr, p2[13:7]);
        repeat (3) begin @(posedge clk); #1; end
        ref_fold(p2, ec, es);
        chk("bp_second_valid", bus.out_valid, 1);
        chk("bp_second_cos", $signed(bus.out_cos), ec);
        chk("bp_second_sin", $signed(bus.out_sin), es);
        @(posedge clk); #1;

        // Reset asserted while in LOOK_B.
        p3 = 16'h3210;
        bus.in_valid = 1'b1;
        bus.in_phase = p3;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rstmid_valid", bus.out_valid, 0);
        chk("rstmid_cos", $signed(bus.out_cos), 0);
        chk("rstmid_sin", $signed(bus.out_sin), 0);
        chk("rstmid_ready", bus.in_ready, 1);
        chk("rstmid_addr", bus.coeff_addr, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen++;
        end
        chk("rstmid_no_stale", seen, 0);
        chk("rstmid_ready_after", bus.in_ready, 1);

        // Randomized sweep against the reference model with a random table.
        for (int i = 0; i < 128; i++) begin
            tc0[i] = 19'($urandom_range(0, 524287));
            tc1[i] = 12'($urandom_range(0, 4095));
        end
        got = 0;
        fork
            begin
                logic [15:0] ph;
                int rc, rs, gap, w;
                bit acc;
                for (int i = 0; i < 1000; i++) begin
                    gap = $urandom_range(0, 2);
                    repeat (gap) begin @(posedge clk); #1; end
                    ph = 16'($urandom);
                    bus.in_valid = 1'b1;
                    bus.in_phase = ph;
                    acc = 1'b0;
                    w = 0;
                    while (!acc && w < 200) begin
                        @(negedge clk);
                        if (bus.in_ready) acc = 1'b1;
                        @(posedge clk); #1;
                        w++;
                    end
                    bus.in_valid = 1'b0;
                    if (!acc) begin
                        timeout_fail("sweep_accept");
                        break;
                    end
                    ref_fold(ph, rc, rs);
                    qc.push_back(rc);
                    qs.push_back(rs);
                end
            end
            begin
                int cyc, ec2, es2;
                cyc = 0;
                while (got < 1000 && cyc < 40000) begin
                    @(posedge clk); #1;
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                    @(negedge clk);
                    if (bus.out_valid && bus.out_ready) begin
                        if (qc.size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL sweep_unexpected actual=output required=none");
                        end else begin
                            ec2 = qc.pop_front();
                            es2 = qs.pop_front();
                            chk($sformatf("sweep_cos_%0d", got), $signed(bus.out_cos), ec2);
                            chk($sformatf("sweep_sin_%0d", got), $signed(bus.out_sin), es2);
                        end
                        got++;
                    end
                    cyc++;
                end
            end
        join
        @(posedge clk); #1;
        chk("sweep_count", got, 1000);
        chk("sweep_leftover", qc.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
